// File: rtl/pid_channel_scheduler.sv
// Shares one staged PID datapath (etapa2/3/4) across NCH control loops, one pass per sample period.
// Optional PID_SAT_EN: clamps stored PWM results to PWM_MAX (integral state is never clamped).
module pid_channel_scheduler #(
    parameter int unsigned     NCH       = 4,
    parameter int unsigned     W         = 9,
    parameter int unsigned     OUTW      = 18,
    parameter int unsigned     PERIOD    = 50000,
    parameter int unsigned     STAGE_CYC = 1,
    parameter logic [OUTW-1:0] PWM_MAX   = 18'h3FFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_en,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH*W-1:0]     y_in,
    input  logic [NCH*W-1:0]     ref_in,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_ch,
    input  logic [1:0]           cfg_sel,
    input  logic [W-1:0]         cfg_data,
    input  logic                 ovr_clr,
    output logic [W-1:0]         dp_y,
    output logic [W-1:0]         dp_ref,
    output logic [W-1:0]         dp_kp,
    output logic [W-1:0]         dp_ki,
    output logic [W-1:0]         dp_kd,
    output logic [OUTW-1:0]      dp_state_in,
    output logic                 dp_state_ld,
    output logic                 dp_etapa2,
    output logic                 dp_etapa3,
    output logic                 dp_etapa4,
    input  logic [OUTW-1:0]      dp_pwm,
    input  logic [OUTW-1:0]      dp_state_out,
    output logic [NCH*OUTW-1:0]  pwm_out,
    output logic [NCH-1:0]       pwm_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned IW = $clog2(NCH + 1);
    localparam int unsigned SW = (STAGE_CYC > 1) ? $clog2(STAGE_CYC) : 1;
    localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [IW-1:0] IDX_END  = IW'(NCH);
    localparam logic [SW-1:0] STG_LAST = SW'(STAGE_CYC - 1);
    localparam logic [TW-1:0] CNT_LAST = TW'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_LOAD, S_ET2, S_ET3, S_ET4, S_CAPT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [SW-1:0]   stg_q, stg_d;
    logic [TW-1:0]   cnt_q;
    logic            tick;
    logic            ovr_q;
    logic [CW-1:0]   cidx;

    logic            win, load, capt;
    logic [W-1:0]    y_sel, ref_sel;
    logic [OUTW-1:0] capt_val;

    logic [W-1:0]    kp_q [NCH];
    logic [W-1:0]    ki_q [NCH];
    logic [W-1:0]    kd_q [NCH];
    logic [OUTW-1:0] st_q [NCH];
    logic [OUTW-1:0] pwm_q [NCH];
    logic [NCH-1:0]  pwm_valid_q;

    logic [W-1:0]    dp_y_q, dp_ref_q, dp_kp_q, dp_ki_q, dp_kd_q;
    logic [OUTW-1:0] dp_st_q;

    assign cidx    = idx_q[CW-1:0];
    assign tick    = start_en && (cnt_q == CNT_LAST);
    assign y_sel   = y_in[cidx*W +: W];
    assign ref_sel = ref_in[cidx*W +: W];

`ifdef PID_SAT_EN
    assign capt_val = (dp_pwm > PWM_MAX) ? PWM_MAX : dp_pwm;
`else
    assign capt_val = dp_pwm;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!start_en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            stg_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stg_d   = stg_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (idx_q == IDX_END) begin
                    state_d = S_IDLE;
                end else if (ch_en[cidx]) begin
                    state_d = S_LOAD;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_ET2;
                stg_d   = '0;
            end
            S_ET2, S_ET3, S_ET4: begin
                if (stg_q == STG_LAST) begin
                    stg_d = '0;
                    case (state_q)
                        S_ET2:   state_d = S_ET3;
                        S_ET3:   state_d = S_ET4;
                        default: state_d = S_CAPT;
                    endcase
                end else begin
                    stg_d = stg_q + 1'b1;
                end
            end
            S_CAPT: begin
                state_d = S_SCAN;
                idx_d   = idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operands follow the live mux during LOAD..CAPT; gains and state are frozen at LOAD.
    always_comb begin
        busy        = (state_q != S_IDLE);
        load        = (state_q == S_LOAD);
        capt        = (state_q == S_CAPT);
        win         = (state_q == S_LOAD) || (state_q == S_ET2) || (state_q == S_ET3) ||
                      (state_q == S_ET4)  || (state_q == S_CAPT);
        dp_state_ld = load;
        dp_etapa2   = (state_q == S_ET2);
        dp_etapa3   = (state_q == S_ET3);
        dp_etapa4   = (state_q == S_ET4);
        dp_y        = win  ? y_sel       : dp_y_q;
        dp_ref      = win  ? ref_sel     : dp_ref_q;
        dp_kp       = load ? kp_q[cidx]  : dp_kp_q;
        dp_ki       = load ? ki_q[cidx]  : dp_ki_q;
        dp_kd       = load ? kd_q[cidx]  : dp_kd_q;
        dp_state_in = load ? st_q[cidx]  : dp_st_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                kp_q[c]  <= '0;
                ki_q[c]  <= '0;
                kd_q[c]  <= '0;
                st_q[c]  <= '0;
                pwm_q[c] <= '0;
            end
            pwm_valid_q <= '0;
            dp_y_q      <= '0;
            dp_ref_q    <= '0;
            dp_kp_q     <= '0;
            dp_ki_q     <= '0;
            dp_kd_q     <= '0;
            dp_st_q     <= '0;
            ovr_q       <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (cfg_we && (32'(cfg_ch) == c)) begin
                    case (cfg_sel)
                        2'd0:    kp_q[c] <= cfg_data;
                        2'd1:    ki_q[c] <= cfg_data;
                        2'd2:    kd_q[c] <= cfg_data;
                        default: ;
                    endcase
                end
                // A clear arriving with this channel's CAPT overrides the captured state.
                if (cfg_we && (cfg_sel == 2'd3) && (32'(cfg_ch) == c)) begin
                    st_q[c] <= '0;
                end else if (capt && (32'(cidx) == c)) begin
                    st_q[c] <= dp_state_out;
                end
                if (capt && (32'(cidx) == c)) begin
                    pwm_q[c] <= capt_val;
                end
                pwm_valid_q[c] <= capt && (32'(cidx) == c);
            end
            if (win) begin
                dp_y_q   <= y_sel;
                dp_ref_q <= ref_sel;
            end
            if (load) begin
                dp_kp_q <= kp_q[cidx];
                dp_ki_q <= ki_q[cidx];
                dp_kd_q <= kd_q[cidx];
                dp_st_q <= st_q[cidx];
            end
            if (tick && busy) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pwm
        assign pwm_out[g*OUTW +: OUTW] = pwm_q[g];
    end

    assign pwm_valid = pwm_valid_q;
    assign overrun   = ovr_q;

endmodule
